// File: rtl/alu_sequencer.sv
// Issue/capture sequencer for the 32-bit ALU datapath.
// It accepts one operation, waits a per-opcode settle time, then returns Z as one or two 32-bit beats.
module alu_sequencer #(
    parameter int unsigned BASIC_LAT = 1,
    parameter int unsigned MUL_LAT   = 4,
    parameter int unsigned DIV_LAT   = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_ra,
    output logic [31:0] alu_rb,
    output logic [4:0]  alu_opcode,
    input  logic [63:0] alu_rz,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned MAX_LAT_AB = (BASIC_LAT > MUL_LAT) ? BASIC_LAT : MUL_LAT;
    localparam int unsigned MAX_LAT    = (MAX_LAT_AB > DIV_LAT) ? MAX_LAT_AB : DIV_LAT;
    localparam int          CNT_W      = $clog2(MAX_LAT) + 1;

    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;

    typedef enum logic [1:0] {IDLE, EXEC, RSP_LO, RSP_HI} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        zValue_q, zValue_d;
    logic               errFlag_q, errFlag_d;
    logic               wideOp_q, wideOp_d;
    logic               divZero_q, divZero_d;
    logic [31:0]        aluRa_q, aluRa_d;
    logic [31:0]        aluRb_q, aluRb_d;
    logic [4:0]         aluOp_q, aluOp_d;

    // 01010 is a hole in the opcode map; everything above 01101 is unused
    function automatic logic isLegal(input logic [4:0] op);
        return (op <= 5'b01101) && (op != 5'b01010);
    endfunction

    function automatic logic [CNT_W-1:0] startCount(input logic [4:0] op);
        if (op == OP_MUL)      return CNT_W'(MUL_LAT - 1);
        else if (op == OP_DIV) return CNT_W'(DIV_LAT - 1);
        else                   return CNT_W'(BASIC_LAT - 1);
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            zValue_q  <= '0;
            errFlag_q <= 1'b0;
            wideOp_q  <= 1'b0;
            divZero_q <= 1'b0;
            aluRa_q   <= '0;
            aluRb_q   <= '0;
            aluOp_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            zValue_q  <= zValue_d;
            errFlag_q <= errFlag_d;
            wideOp_q  <= wideOp_d;
            divZero_q <= divZero_d;
            aluRa_q   <= aluRa_d;
            aluRb_q   <= aluRb_d;
            aluOp_q   <= aluOp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        zValue_d  = zValue_q;
        errFlag_d = errFlag_q;
        wideOp_d  = wideOp_q;
        divZero_d = divZero_q;
        aluRa_d   = aluRa_q;
        aluRb_d   = aluRb_q;
        aluOp_d   = aluOp_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    aluRa_d   = req_a;
                    aluRb_d   = req_b;
                    aluOp_d   = req_op;
                    wideOp_d  = (req_op == OP_MUL) || (req_op == OP_DIV);
                    divZero_d = (req_op == OP_DIV) && (req_b == 32'd0);
                    if (!isLegal(req_op)) begin
                        zValue_d  = '0;
                        errFlag_d = 1'b1;
                        state_d   = RSP_LO;
                    end else begin
                        errFlag_d = (req_op == OP_DIV) && (req_b == 32'd0);
                        cnt_d     = startCount(req_op);
                        state_d   = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Divide-by-zero reports the dividend in HI and all-ones in LO
                    zValue_d = divZero_q ? {aluRa_q, 32'hFFFF_FFFF} : alu_rz;
                    state_d  = RSP_LO;
                end
            end
            RSP_LO: begin
                if (rsp_ready) state_d = wideOp_q ? RSP_HI : IDLE;
            end
            RSP_HI: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == RSP_LO) || (state_q == RSP_HI);
    assign rsp_data   = (state_q == RSP_LO) ? zValue_q[31:0]
                      : (state_q == RSP_HI) ? zValue_q[63:32] : 32'd0;
    assign rsp_last   = (state_q == RSP_HI) || ((state_q == RSP_LO) && !wideOp_q);
    assign rsp_err    = rsp_valid && errFlag_q;
    assign alu_ra     = aluRa_q;
    assign alu_rb     = aluRb_q;
    assign alu_opcode = aluOp_q;

endmodule
